// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file writeback path.
package reg_file_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RR_R0 = 1'b0,
    RR_R1 = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending writeback requests for one requester.
module wb_fifo
  import reg_file_pkg::*;
#(
  parameter type         T     = wb_req_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? inc_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? inc_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the reg_file write port between ALU (r0) and
// load (r1) writeback, with a per-register outstanding-write mask.
module reg_file_wr_arbiter #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [ADDR_W-1:0]    r0_addr,
  input  logic [DATA_W-1:0]    r0_data,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [ADDR_W-1:0]    r1_addr,
  input  logic [DATA_W-1:0]    r1_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending_mask
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(2 * DEPTH + 2);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t                  push0, push1, head0, head1, head_sel;
  logic                  full0, full1, empty0, empty1;
  logic                  acc0, acc1, gnt0, gnt1, pop;
  reg_file_pkg::rr_sel_e rr_q, rr_d;
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [CNT_W-1:0]      cnt_q [NREG];
  logic [CNT_W-1:0]      cnt_d [NREG];

  assign r0_ready = reset_n && !full0;
  assign r1_ready = reset_n && !full1;
  assign acc0     = r0_valid && r0_ready;
  assign acc1     = r1_valid && r1_ready;
  assign push0    = '{addr: r0_addr, data: r0_data};
  assign push1    = '{addr: r1_addr, data: r1_data};

  wb_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo_r0 (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .push_i   (acc0),
    .din_i    (push0),
    .pop_i    (gnt0),
    .full_o   (full0),
    .empty_o  (empty0),
    .head_o   (head0)
  );

  wb_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo_r1 (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .push_i   (acc1),
    .din_i    (push1),
    .pop_i    (gnt1),
    .full_o   (full1),
    .empty_o  (empty1),
    .head_o   (head1)
  );

  always_comb begin
    gnt0     = !empty0 && (empty1 || (rr_q == reg_file_pkg::RR_R0));
    gnt1     = !empty1 && !gnt0;
    pop      = gnt0 || gnt1;
    head_sel = gnt0 ? head0 : head1;
    rr_d     = rr_q;
    if (gnt0) rr_d = reg_file_pkg::RR_R1;
    else if (gnt1) rr_d = reg_file_pkg::RR_R0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q    <= reg_file_pkg::RR_R0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wr_en_q <= pop;
      if (pop) begin
        waddr_q <= head_sel.addr;
        wdata_q <= head_sel.data;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;

  // Both accepts and the pop may hit one register in the same cycle; apply the net.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i]
               + CNT_W'(acc0 && (r0_addr == ADDR_W'(i)))
               + CNT_W'(acc1 && (r1_addr == ADDR_W'(i)))
               - CNT_W'(pop && (head_sel.addr == ADDR_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!reset_n) cnt_q[i] <= '0;
      else          cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pending_mask[i] = (cnt_q[i] != '0);
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter with a behavioural reg_file and a
// scoreboard of expected write-port transactions.
module tb_reg_file_wr_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              r0_valid, r0_ready, r1_valid, r1_ready;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_data, r1_data;
  logic              wr_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending_mask;

  logic [DATA_W-1:0] rf [NREG] = '{default: '0};

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  reg_file_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_addr      (r0_addr),
    .r0_data      (r0_data),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_addr      (r1_addr),
    .r1_data      (r1_data),
    .wr_en        (wr_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  // Behavioural reg_file write port.
  always @(posedge clk) begin
    if (wr_en === 1'b1) rf[write_addr] <= write_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write presented to reg_file must be the next expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                 write_addr, write_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(write_addr), 64'(e.a));
        check("wr_data", 64'(write_data), 64'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    r0_valid = v0; r0_addr = a0; r0_data = d0;
    r1_valid = v1; r1_addr = a1; r1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    tick();
    check("rst_r0_ready", 64'(r0_ready), 64'd0);
    check("rst_r1_ready", 64'(r1_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_pending", 64'(pending_mask), 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] sv_addr;
    logic [DATA_W-1:0] sv_data;
    int   i0, i1;
    bit   a0, a1, dropped;

    reset_n = 1'b0;
    idle();
    tick();
    tick();
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_write_addr", 64'(write_addr), 64'd0);
    check("reset_write_data", 64'(write_data), 64'd0);
    check("reset_pending", 64'(pending_mask), 64'd0);
    check("reset_r0_ready", 64'(r0_ready), 64'd0);
    check("reset_r1_ready", 64'(r1_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("post_reset_r0_ready", 64'(r0_ready), 64'd1);
    check("post_reset_r1_ready", 64'(r1_ready), 64'd1);

    // 1: single r0 write, two-edge latency
    expect_wr(4'd1, 32'd10);
    drive(1'b1, 4'd1, 32'd10, 1'b0, '0, '0);
    tick();
    idle();
    check("t1_pending_set", 64'(pending_mask), 64'h0002);
    check("t1_wr_en_k1", 64'(wr_en), 64'd0);
    tick();
    check("t1_wr_en_k2", 64'(wr_en), 64'd1);
    check("t1_write_addr", 64'(write_addr), 64'd1);
    check("t1_write_data", 64'(write_data), 64'd10);
    check("t1_pending_clr", 64'(pending_mask), 64'd0);
    tick();
    check("t1_wr_en_k3", 64'(wr_en), 64'd0);
    check("t1_rf1", 64'(rf[1]), 64'd10);

    // 2: both valid every cycle, grants alternate r0,r1,r0,r1
    do_reset();
    expect_wr(4'd2, 32'd12);
    expect_wr(4'd6, 32'd16);
    expect_wr(4'd3, 32'd13);
    expect_wr(4'd0, 32'd4);
    drive(1'b1, 4'd2, 32'd12, 1'b1, 4'd6, 32'd16);
    tick();
    drive(1'b1, 4'd3, 32'd13, 1'b1, 4'd0, 32'd4);
    tick();
    idle();
    repeat (5) tick();
    check("t2_rf3", 64'(rf[3]), 64'd13);
    check("t2_rf0", 64'(rf[0]), 64'd4);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: backpressure on r1 while r0 keeps the port busy
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expect_wr(ADDR_W'(8 + k), DATA_W'(32'h80 + k));
      expect_wr(ADDR_W'(12 + k), DATA_W'(32'hC0 + k));
    end
    i0 = 0; i1 = 0; dropped = 1'b0;
    for (int cyc = 0; cyc < 40 && (i0 < 4 || i1 < 4); cyc++) begin
      drive(i0 < 4, ADDR_W'(8 + i0), DATA_W'(32'h80 + i0),
            i1 < 4, ADDR_W'(12 + i1), DATA_W'(32'hC0 + i1));
      #1;
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (r1_valid && !r1_ready && !dropped) begin
        dropped = 1'b1;
        check("t3_r1_ready_drop_after", 64'(i1), 64'd2);
      end
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    idle();
    check("t3_all_accepted", 64'(i0 + i1), 64'd8);
    check("t3_r1_ready_dropped", 64'(dropped), 64'd1);
    repeat (6) tick();
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: same destination from both requesters in one cycle
    do_reset();
    expect_wr(4'd3, 32'd100);
    expect_wr(4'd3, 32'd7);
    drive(1'b1, 4'd3, 32'd100, 1'b1, 4'd3, 32'd7);
    tick();
    idle();
    check("t4_pending_two", 64'(pending_mask), 64'h0008);
    tick();
    check("t4_pending_after_first", 64'(pending_mask), 64'h0008);
    tick();
    check("t4_pending_after_second", 64'(pending_mask), 64'd0);
    tick();
    check("t4_rf3_later_grant", 64'(rf[3]), 64'd7);

    // 6: idle keeps wr_en low and holds the last address/data
    sv_addr = write_addr;
    sv_data = write_data;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t6_idle_wr_en", 64'(wr_en), 64'd0);
    end
    check("t6_addr_held", 64'(write_addr), 64'(sv_addr));
    check("t6_data_held", 64'(write_data), 64'd7);

    // 5: reset with writes queued; queued entries must never reach reg_file
    do_reset();
    expect_wr(4'd4, 32'h44);
    expect_wr(4'd5, 32'h55);
    drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55);
    tick();
    drive(1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 32'h79);
    tick();
    drive(1'b1, 4'd7, 32'h78, 1'b1, 4'd7, 32'h7A);
    tick();
    check("t5_pending7_before_rst", 64'(pending_mask[7]), 64'd1);
    reset_n = 1'b0;
    idle();
    tick();
    check("t5_rst_r0_ready", 64'(r0_ready), 64'd0);
    check("t5_rst_r1_ready", 64'(r1_ready), 64'd0);
    check("t5_rst_wr_en", 64'(wr_en), 64'd0);
    check("t5_rst_pending", 64'(pending_mask), 64'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_post_rst_wr_en", 64'(wr_en), 64'd0);
    end
    check("t5_rf4", 64'(rf[4]), 64'h44);
    check("t5_rf5", 64'(rf[5]), 64'h55);
    check("t5_rf7_untouched", 64'(rf[7]), 64'd0);

    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
